dma_cmd_queue: RTL

- Register-mapped command front-end that sits directly upstream of the DMA engine.
- Software writes source, destination and length into staging registers, then pushes them as a descriptor into a small FIFO.
- A sequencer pops descriptors one at a time and drives the DMA's config/length/source/dest inputs. It monitors the DMA state word, retires the job with clr_done and raises a completion interrupt.

---
 rtl/dma_cmd_queue.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_cmd_queue.sv
// Register-mapped descriptor queue and sequencer feeding a single-channel DMA engine.
// Optional watchdog on stalled jobs is enabled by defining DMA_CMDQ_TIMEOUT_EN.
module dma_cmd_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int CONF_START     = 0,
  parameter int CONF_CLR_DONE  = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [4:0]            reg_addr_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic [DATA_WIDTH-1:0] reg_rdata_o,
  output logic                  reg_rvalid_o,
  output logic [DATA_WIDTH-1:0] config_o,
  output logic [DATA_WIDTH-1:0] length_o,
  output logic [DATA_WIDTH-1:0] source_addr_o,
  output logic [DATA_WIDTH-1:0] dest_addr_o,
  input  logic [DATA_WIDTH-1:0] state_i,
  output logic                  irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [4:0] A_SRC    = 5'h00;
  localparam logic [4:0] A_DST    = 5'h04;
  localparam logic [4:0] A_LEN    = 5'h08;
  localparam logic [4:0] A_PUSH   = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;
  localparam logic [4:0] A_DONE   = 5'h14;
  localparam logic [4:0] A_IRQ    = 5'h18;
  localparam logic [4:0] A_IRQEN  = 5'h1C;

  localparam logic [2:0] DMA_IDLE = 3'd0;
  localparam logic [2:0] DMA_DONE = 3'd5;

  typedef enum logic [1:0] {SQ_IDLE, SQ_ISSUE, SQ_WAIT, SQ_CLEAR} sq_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] src;
    logic [DATA_WIDTH-1:0] dst;
    logic [DATA_WIDTH-1:0] len;
  } desc_t;

  logic wr, rd, w1c;
  logic [2:0] dma_st;
  assign wr     = reg_req_i & reg_we_i;
  assign rd     = reg_req_i & ~reg_we_i;
  assign w1c    = wr && (reg_addr_i == A_IRQ);
  assign dma_st = state_i[2:0];

  logic unused_state;
  assign unused_state = ^state_i[DATA_WIDTH-1:3];

  // Staging and enable registers
  logic [DATA_WIDTH-1:0] src_q, dst_q, len_q;
  logic irq_en_q, irq_en_d;
  assign irq_en_d = (wr && reg_addr_i == A_IRQEN) ? reg_wdata_i[0] : irq_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      if (wr) begin
        unique case (reg_addr_i)
          A_SRC:   src_q <= reg_wdata_i;
          A_DST:   dst_q <= reg_wdata_i;
          A_LEN:   len_q <= reg_wdata_i;
          default: ;
        endcase
      end
    end
  end

  // Descriptor FIFO
  desc_t          mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full, empty, push, push_ok, pop;
  sq_e            seq_q, seq_d;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign push    = wr && (reg_addr_i == A_PUSH);
  assign push_ok = push & ~full;
  assign pop     = (seq_q == SQ_CLEAR) && (dma_st == DMA_IDLE);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= {src_q, dst_q, len_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
    end
  end

  // Sequencer
  logic [DATA_WIDTH-1:0] cfg;

  always_comb begin
    seq_d = seq_q;
    cfg   = '0;
    unique case (seq_q)
      SQ_IDLE:  if (!empty) seq_d = SQ_ISSUE;
      SQ_ISSUE: begin
        cfg[CONF_START] = 1'b1;
        if (dma_st != DMA_IDLE) seq_d = SQ_WAIT;
      end
      SQ_WAIT:  if (dma_st == DMA_DONE) seq_d = SQ_CLEAR;
      SQ_CLEAR: begin
        cfg[CONF_CLR_DONE] = 1'b1;
        if (dma_st == DMA_IDLE) seq_d = SQ_IDLE;
      end
      default:  seq_d = SQ_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] src_o_q, dst_o_q, len_o_q, done_cnt_q;

  // Head is latched on the IDLE->ISSUE edge and held until the next job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_q      <= SQ_IDLE;
      src_o_q    <= '0;
      dst_o_q    <= '0;
      len_o_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      seq_q <= seq_d;
      if (seq_q == SQ_IDLE && !empty) begin
        src_o_q <= mem_q[rptr_q].src;
        dst_o_q <= mem_q[rptr_q].dst;
        len_o_q <= mem_q[rptr_q].len;
      end
      if (pop) done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign config_o      = cfg;
  assign source_addr_o = src_o_q;
  assign dest_addr_o   = dst_o_q;
  assign length_o      = len_o_q;

  // Watchdog
  logic tmo_hit;
`ifdef DMA_CMDQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Saturates at the limit so the sticky bit fires once per job.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (pop) begin
      tmo_cnt_d = '0;
    end else if (seq_q != SQ_IDLE && tmo_cnt_q < TMO_LIM) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      tmo_hit   = (tmo_cnt_d == TMO_LIM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  // Sticky event bits: a set in the same cycle as a W1C wins.
  logic pend_q, ovf_q, tmo_q, irq_q;
  logic pend_d, ovf_d, tmo_d;

  always_comb begin
    pend_d = pop          ? 1'b1 : (w1c && reg_wdata_i[0]) ? 1'b0 : pend_q;
    ovf_d  = (push&&full) ? 1'b1 : (w1c && reg_wdata_i[8]) ? 1'b0 : ovf_q;
    tmo_d  = tmo_hit      ? 1'b1 : (w1c && reg_wdata_i[9]) ? 1'b0 : tmo_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
      irq_q  <= irq_en_d & (pend_d | ovf_d | tmo_d);
    end
  end

  assign irq_o = irq_q;

  // Read path
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  rvalid_q;
  logic [4:0]            cnt_ext;
  assign cnt_ext = 5'(cnt_q);

  always_comb begin
    rdata_d = '0;
    unique case (reg_addr_i)
      A_SRC:    rdata_d = src_q;
      A_DST:    rdata_d = dst_q;
      A_LEN:    rdata_d = len_q;
      A_STATUS: begin
        rdata_d[0]     = (seq_q != SQ_IDLE);
        rdata_d[1]     = full;
        rdata_d[2]     = empty;
        rdata_d[7:4]   = cnt_ext[3:0];
        rdata_d[8]     = ovf_q;
        rdata_d[9]     = tmo_q;
        rdata_d[14:12] = dma_st;
      end
      A_DONE:   rdata_d = done_cnt_q;
      A_IRQ: begin
        rdata_d[0] = pend_q;
        rdata_d[8] = ovf_q;
        rdata_d[9] = tmo_q;
      end
      A_IRQEN:  rdata_d[0] = irq_en_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd;
      rdata_q  <= rd ? rdata_d : '0;
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;

endmodule
